mem_access_stage: RTL
=====================

# mem_access_stage

Pipeline MEM stage sitting directly downstream of the EX/MEM buffer and feeding the MEM/WB buffer. It owns the word-organised data RAM and performs lw/lh/lhu/lb/lbu/sw/sh/sb with little-endian lane selection and sign/zero extension. A counter-driven FSM stretches each access to `LATENCY` cycles, holding the upstream stages with `MemStall_out`. Results are registered for writeback, and a bubble is inserted while a stall is in progress.

## Interface
- `DEPTH_WORDS`, default 1024: RAM depth in 32-bit words, power of 2. The word index is `ALUResult_in[log2(DEPTH_WORDS)+1:2]`; upper address bits are ignored, so addresses wrap.
- `LATENCY`, default 2: cycles per memory access, minimum 1.
- `Clk`, input, 1: the single clock; all state changes on its rising edge.
- `Rst`, input, 1: synchronous, active-high reset.
- `instruction_in`, input, 32: opcode in `[31:26]` selects the access size.
- `ALUResult_in`, input, 32: effective address for memory ops; the result value for all other ops.
- `ReadData2_in`, input, 32: store data.
- `WriteReg_in`, input, 5: destination register.
- `RegWrite_in`, `MemRead_in`, `MemWrite_in`, input, 1 each: control bits.
- `MemStall_out`, output, 1: combinational; while high, upstream PC/IF/ID/EX/EX-MEM registers must hold.
- `ReadData_out`, output, 32: extended load data, registered.
- `ALUResult_out`, output, 32: registered pass-through of `ALUResult_in`.
- `WriteReg_out`, output, 5: registered.
- `RegWrite_out`, output, 1: registered.
- `MemToReg_out`, output, 1: registered; high when the completed instruction was a load.
- `AlignFault_out`, output, 1: registered; high for the instruction that was misaligned.

## Operation
- Size decode from `instruction_in[31:26]`:
  - 0x23 lw, 0x2B sw: word.
  - 0x21 lh, 0x25 lhu, 0x29 sh: half.
  - 0x20 lb, 0x24 lbu, 0x28 sb: byte.
  - Any other opcode with `MemRead_in` or `MemWrite_in` set is treated as a word access.
- Alignment rules: a word access is misaligned if `addr[1:0]!=0`; a half access if `addr[0]!=0`.
- A request is present when `MemRead_in|MemWrite_in` is high and the address is aligned. If both read and write are high, the write wins and `MemToReg_out` is 0.
- Lanes are little-endian.
  - Byte `n` is `word[8n+7:8n]`, with `n=addr[1:0]`.
  - Half `h` is `word[16h+15:16h]`, with `h=addr[1]`.
- Loads: lb/lh sign-extend; lbu/lhu zero-extend.
- Stores modify only the selected lanes; the other bytes of the word are preserved.
- FSM states are IDLE and WAIT, plus a counter `cnt` of width `clog2(LATENCY)`.
  - IDLE, no request: `MemStall_out=0`. Completes as a pass-through.
  - IDLE, request, `LATENCY==1`: `MemStall_out=0`. Access completes at this edge.
  - IDLE, request, `LATENCY>1`: `MemStall_out=1`. Next state is WAIT with `cnt=LATENCY-2`.
  - WAIT, `cnt!=0`: `MemStall_out=1`, `cnt` decrements.
  - WAIT, `cnt==0`: `MemStall_out=0`. Access completes at this edge; next state is IDLE.
- On completion, outputs load from the current inputs and the store commits to RAM at the same edge.
- Misaligned access:
  - No RAM access and no stall; completes in one cycle.
  - `AlignFault_out=1`, `RegWrite_out=0`, `MemToReg_out=0`.
- Any cycle with `MemStall_out=1` loads a bubble into the output registers: `RegWrite_out=0`, `MemToReg_out=0`, `AlignFault_out=0`; other outputs hold.
- Pass-through (non-memory) instructions copy `RegWrite_in`, `WriteReg_in` and `ALUResult_in`. `ReadData_out` holds its previous value.

## Timing
- Reset values: all registered outputs 0, state IDLE, `cnt=0`. `MemStall_out=0` while `Rst` is high. RAM contents are not reset.
- Non-memory or misaligned instruction: 1-cycle latency, zero stall cycles.
- Memory access accepted in cycle T:
  - `MemStall_out` is high in cycles T..T+LATENCY-2.
  - Result is registered at the end of cycle T+LATENCY-1 and visible from cycle T+LATENCY.
  - The next instruction can be accepted in cycle T+LATENCY.
- Back-to-back memory ops: each gets the full `LATENCY`, with no overlap between accesses.
- Load after store to the same word: the load returns the new data, since the store committed at an earlier edge.
- `Rst` during WAIT:
  - Access is aborted; a pending store is not written.
  - State returns to IDLE and `MemStall_out` is 0 from the reset cycle.
- Inputs are sampled only in the completion cycle. Upstream holds them stable during the stall, so mid-access input changes are a protocol violation and the response is unspecified.

## Test plan
- **Reset:** `Rst=1` for 2 cycles with `MemRead_in=1` -> all outputs 0, `MemStall_out=0`.
- **Store then load, `LATENCY=2`:**
  - sw `0xDEADBEEF` to addr `0x10` -> stall high 1 cycle.
  - sb `0x7F` to addr `0x13` (preset) -> `MemStall_out` high for 1 cycle.
  - lw `0x10` -> `ReadData_out=0x7FADBEEF`, `MemToReg_out=1`, 1 stall cycle.
- **Extension:** word `0x80FF8001` at addr 0.
  - lb `0x0` -> `0x00000001`.
  - lb `0x3` -> `0xFFFFFF80`.
  - lbu `0x1` -> `0x00000080`.
  - lh `0x2` -> `0xFFFF80FF`.
  - lhu `0x2` -> `0x000080FF`.
- **Misaligned:** lw addr `0x6` -> no stall, `AlignFault_out=1`, `RegWrite_out=0`, RAM unchanged.
- **Reset mid-access:** `LATENCY=4`, sw `0x12345678` to `0x20`, `Rst` asserted in the 2nd stall cycle, then lw `0x20` -> old contents returned.
- **Wrap and latency sweep:** `DEPTH_WORDS=16`; sw to `0x40`, then lw `0x0` returns the same data. Repeat with `LATENCY=1` (no stall ever) and `LATENCY=3` (exactly 2 stall cycles per access).

Source files
------------

// File: rtl/mem_access_stage.sv
// MEM pipeline stage: owns the word-organised data RAM, performs byte/half/word
// loads and stores with little-endian lanes, and stretches each aligned access
// to LATENCY cycles. While an access is stretched, MemStall_out holds upstream
// and a bubble is loaded into the MEM/WB output registers.
// Handshake: there is no valid/ready pair; MemStall_out=1 means "inputs not
// consumed, hold them stable"; inputs are consumed at any edge where
// MemStall_out=0 and Rst=0.
module mem_access_stage #(
  parameter int DEPTH_WORDS = 1024,
  parameter int LATENCY     = 2
) (
  input  logic        Clk,
  input  logic        Rst,
  input  logic [31:0] instruction_in,
  input  logic [31:0] ALUResult_in,
  input  logic [31:0] ReadData2_in,
  input  logic [4:0]  WriteReg_in,
  input  logic        RegWrite_in,
  input  logic        MemRead_in,
  input  logic        MemWrite_in,
  output logic        MemStall_out,
  output logic [31:0] ReadData_out,
  output logic [31:0] ALUResult_out,
  output logic [4:0]  WriteReg_out,
  output logic        RegWrite_out,
  output logic        MemToReg_out,
  output logic        AlignFault_out
);

  localparam int AW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam int CW = (LATENCY > 1) ? $clog2(LATENCY) : 1;
  localparam logic [CW-1:0] CNT_INIT = CW'((LATENCY > 1) ? LATENCY - 2 : 0);

  typedef enum logic {IDLE = 1'b0, WAIT = 1'b1} state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;

  logic [31:0] ram [DEPTH_WORDS];

  logic [5:0]    opcode;
  logic [AW-1:0] word_idx;
  logic          is_half, is_byte, is_signed;
  logic          mem_op, misaligned, req;
  logic          stall, complete;
  logic [31:0]   rd_word, load_val, wr_word, wr_rep;
  logic [7:0]    lane_b;
  logic [15:0]   lane_h;
  logic [3:0]    byte_en;

  logic [31:0] read_data_q, read_data_d;
  logic [31:0] alu_result_q, alu_result_d;
  logic [4:0]  write_reg_q, write_reg_d;
  logic        reg_write_q, reg_write_d;
  logic        mem_to_reg_q, mem_to_reg_d;
  logic        align_fault_q, align_fault_d;

  // Upper address bits and the non-opcode instruction bits are intentionally ignored.
  logic unused_bits;
  assign unused_bits = ^{instruction_in[25:0], ALUResult_in[31:AW+2]};

  assign opcode   = instruction_in[31:26];
  assign word_idx = ALUResult_in[AW+1:2];
  assign rd_word  = ram[word_idx];

  // Size decode, alignment check and request qualification.
  always_comb begin
    is_half   = 1'b0;
    is_byte   = 1'b0;
    is_signed = 1'b0;
    case (opcode)
      6'h21:        begin is_half = 1'b1; is_signed = 1'b1; end
      6'h25, 6'h29: is_half = 1'b1;
      6'h20:        begin is_byte = 1'b1; is_signed = 1'b1; end
      6'h24, 6'h28: is_byte = 1'b1;
      default:      ;
    endcase
    mem_op = MemRead_in | MemWrite_in;
    if (is_byte)      misaligned = 1'b0;
    else if (is_half) misaligned = mem_op & ALUResult_in[0];
    else              misaligned = mem_op & (ALUResult_in[1:0] != 2'b00);
    req = mem_op & ~misaligned;
  end

  // Lane selection and sign/zero extension of load data.
  always_comb begin
    case (ALUResult_in[1:0])
      2'd0:    lane_b = rd_word[7:0];
      2'd1:    lane_b = rd_word[15:8];
      2'd2:    lane_b = rd_word[23:16];
      default: lane_b = rd_word[31:24];
    endcase
    lane_h = ALUResult_in[1] ? rd_word[31:16] : rd_word[15:0];
    if (is_byte)      load_val = is_signed ? {{24{lane_b[7]}}, lane_b} : {24'h0, lane_b};
    else if (is_half) load_val = is_signed ? {{16{lane_h[15]}}, lane_h} : {16'h0, lane_h};
    else              load_val = rd_word;
  end

  // Store merge: only the addressed lanes change, other bytes are preserved.
  always_comb begin
    if (is_byte) begin
      byte_en = 4'b0001 << ALUResult_in[1:0];
      wr_rep  = {4{ReadData2_in[7:0]}};
    end else if (is_half) begin
      byte_en = ALUResult_in[1] ? 4'b1100 : 4'b0011;
      wr_rep  = {2{ReadData2_in[15:0]}};
    end else begin
      byte_en = 4'b1111;
      wr_rep  = ReadData2_in;
    end
    for (int i = 0; i < 4; i++)
      wr_word[8*i +: 8] = byte_en[i] ? wr_rep[8*i +: 8] : rd_word[8*i +: 8];
  end

  // FSM state and latency counter register.
  always_ff @(posedge Clk) begin
    if (Rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // FSM next state: enter WAIT to stretch an access, count down, then return.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (req && (LATENCY > 1)) begin
          state_d = WAIT;
          cnt_d   = CNT_INIT;
        end
      end
      WAIT: begin
        if (cnt_q != '0) cnt_d = cnt_q - CW'(1);
        else             state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // FSM outputs: stall while stretching, complete on the final access cycle.
  always_comb begin
    stall    = 1'b0;
    complete = 1'b0;
    case (state_q)
      IDLE: begin
        if (req && (LATENCY > 1)) stall = 1'b1;
        else                      complete = 1'b1;
      end
      WAIT: begin
        if (cnt_q != '0) stall = 1'b1;
        else             complete = 1'b1;
      end
      default: ;
    endcase
  end

  assign MemStall_out = stall & ~Rst;

  // Next value of the MEM/WB registers: bubble on stall, result on completion.
  always_comb begin
    read_data_d   = read_data_q;
    alu_result_d  = alu_result_q;
    write_reg_d   = write_reg_q;
    reg_write_d   = reg_write_q;
    mem_to_reg_d  = mem_to_reg_q;
    align_fault_d = align_fault_q;
    if (stall) begin
      reg_write_d   = 1'b0;
      mem_to_reg_d  = 1'b0;
      align_fault_d = 1'b0;
    end else if (complete) begin
      alu_result_d = ALUResult_in;
      write_reg_d  = WriteReg_in;
      if (misaligned) begin
        reg_write_d   = 1'b0;
        mem_to_reg_d  = 1'b0;
        align_fault_d = 1'b1;
      end else begin
        reg_write_d   = RegWrite_in;
        align_fault_d = 1'b0;
        mem_to_reg_d  = req & MemRead_in & ~MemWrite_in;
        if (req && MemRead_in && !MemWrite_in) read_data_d = load_val;
      end
    end
  end

  // MEM/WB output registers.
  always_ff @(posedge Clk) begin
    if (Rst) begin
      read_data_q   <= '0;
      alu_result_q  <= '0;
      write_reg_q   <= '0;
      reg_write_q   <= 1'b0;
      mem_to_reg_q  <= 1'b0;
      align_fault_q <= 1'b0;
    end else begin
      read_data_q   <= read_data_d;
      alu_result_q  <= alu_result_d;
      write_reg_q   <= write_reg_d;
      reg_write_q   <= reg_write_d;
      mem_to_reg_q  <= mem_to_reg_d;
      align_fault_q <= align_fault_d;
    end
  end

  // Store commit at the completion edge; a reset aborts a pending store.
  always_ff @(posedge Clk) begin
    if (!Rst && complete && req && MemWrite_in) ram[word_idx] <= wr_word;
  end

  assign ReadData_out   = read_data_q;
  assign ALUResult_out  = alu_result_q;
  assign WriteReg_out   = write_reg_q;
  assign RegWrite_out   = reg_write_q;
  assign MemToReg_out   = mem_to_reg_q;
  assign AlignFault_out = align_fault_q;

endmodule
